// File: rtl/eth_packet_tx.sv
// Byte-stream Ethernet frame transmitter: header, ready/valid payload, zero pad,
// one-cycle terminator and inter-frame gap. All outputs are registered.
module eth_packet_tx #(
  parameter int unsigned MIN_PAYLOAD = 46,
  parameter int unsigned MAX_PAYLOAD = 1500,
  parameter int unsigned IFG         = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [47:0] dest_addr,
  input  logic [47:0] src_addr,
  input  logic [15:0] type_length,
  input  logic [10:0] payload_len,
  input  logic [7:0]  payload_data,
  input  logic        payload_valid,
  output logic        payload_ready,
  output logic        control,
  output logic [7:0]  data,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [10:0] MIN_L = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MAX_L = 11'(MAX_PAYLOAD);
  localparam logic [10:0] IFG_L = 11'(IFG);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_PAD,
    S_EOP,
    S_GAP
  } state_t;

  // state_q names what the registered outputs are showing in the current cycle
  state_t       state_q, state_d;
  logic [10:0]  cnt_q, cnt_d;
  logic [10:0]  len_q, len_d;
  logic [111:0] hdr_q, hdr_d;
  logic         control_q, control_d;
  logic [7:0]   data_q, data_d;
  logic         ready_q, ready_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         error_q, error_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    hdr_d     = hdr_q;
    control_d = 1'b0;
    data_d    = '0;
    ready_d   = 1'b0;
    busy_d    = 1'b1;
    done_d    = 1'b0;
    error_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          if (payload_len > MAX_L) begin
            error_d = 1'b1;
          end else begin
            state_d   = S_HEADER;
            cnt_d     = '0;
            len_d     = payload_len;
            hdr_d     = {dest_addr[39:0], src_addr, type_length, 8'h00};
            data_d    = dest_addr[47:40];
            control_d = 1'b1;
            busy_d    = 1'b1;
          end
        end
      end

      S_HEADER: begin
        if (cnt_q != 11'd13) begin
          cnt_d     = cnt_q + 11'd1;
          data_d    = hdr_q[111:104];
          hdr_d     = hdr_q << 8;
          control_d = 1'b1;
          ready_d   = (cnt_q == 11'd12) && (len_q != '0);
        end else if (len_q == '0) begin
          state_d   = S_PAD;
          cnt_d     = '0;
          control_d = 1'b1;
        end else if (payload_valid) begin
          state_d   = S_PAYLOAD;
          cnt_d     = '0;
          data_d    = payload_data;
          control_d = 1'b1;
          ready_d   = (11'd1 < len_q);
        end else begin
          state_d = S_EOP;
          error_d = 1'b1;
        end
      end

      S_PAYLOAD: begin
        if (ready_q) begin
          if (payload_valid) begin
            cnt_d     = cnt_q + 11'd1;
            data_d    = payload_data;
            control_d = 1'b1;
            ready_d   = (cnt_q + 11'd2 < len_q);
          end else begin
            state_d = S_EOP;
            error_d = 1'b1;
          end
        end else if (len_q < MIN_L) begin
          // pad continues the payload position count up to MIN_L
          state_d   = S_PAD;
          cnt_d     = len_q;
          control_d = 1'b1;
        end else begin
          state_d = S_EOP;
          done_d  = 1'b1;
        end
      end

      S_PAD: begin
        if (cnt_q + 11'd1 < MIN_L) begin
          cnt_d     = cnt_q + 11'd1;
          control_d = 1'b1;
        end else begin
          state_d = S_EOP;
          done_d  = 1'b1;
        end
      end

      S_EOP: begin
        state_d = S_GAP;
        cnt_d   = '0;
      end

      S_GAP: begin
        if (cnt_q + 11'd1 < IFG_L) begin
          cnt_d = cnt_q + 11'd1;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      hdr_q     <= '0;
      control_q <= 1'b0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      hdr_q     <= hdr_d;
      control_q <= control_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign payload_ready = ready_q;
  assign control       = control_q;
  assign data          = data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule
